// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
//   Instruction fetch front end: a loader-writable instruction memory, a
//   fetch PC and a small FIFO of {pc, instruction} entries feeding decode.
//
// Ports
//   i_clk, i_reset          clock, synchronous active-high reset
//   i_step                  global advance enable (0 freezes PC/queue/halt)
//   i_load_we/addr/data     loader write port into instruction memory
//   i_redirect/_pc          taken-branch redirect (flushes queue)
//   i_id_ready              decode accepts the head entry
//   o_valid                 head entry valid
//   o_instruction/o_pc      head entry; o_pc4/o_pc8 = o_pc+4/+8
//   o_count                 occupied entries
//   o_halt                  halt word fetched and queue drained
// ---------------------------------------------------------------------------
module if_fetch_queue #(
  parameter int                   BITS_SIZE   = 32,
  parameter int                   MEM_WORDS   = 64,
  parameter int                   QUEUE_DEPTH = 4,
  parameter logic [BITS_SIZE-1:0] RESET_PC    = '0,
  parameter logic [BITS_SIZE-1:0] HALT_WORD   = 32'hFFFFFFFF,
  localparam int                  CW          = $clog2(QUEUE_DEPTH) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_step,
  input  logic                 i_load_we,
  input  logic [BITS_SIZE-1:0] i_load_addr,
  input  logic [BITS_SIZE-1:0] i_load_data,
  input  logic                 i_redirect,
  input  logic [BITS_SIZE-1:0] i_redirect_pc,
  input  logic                 i_id_ready,
  output logic                 o_valid,
  output logic [BITS_SIZE-1:0] o_instruction,
  output logic [BITS_SIZE-1:0] o_pc,
  output logic [BITS_SIZE-1:0] o_pc4,
  output logic [BITS_SIZE-1:0] o_pc8,
  output logic [CW-1:0]        o_count,
  output logic                 o_halt
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int PW = $clog2(QUEUE_DEPTH);

  // instruction memory (no reset: contents survive i_reset)
  logic [BITS_SIZE-1:0] mem_q [MEM_WORDS];

  // queue storage, indexed by head/tail pointers that wrap naturally
  logic [BITS_SIZE-1:0] q_pc_q    [QUEUE_DEPTH];
  logic [BITS_SIZE-1:0] q_instr_q [QUEUE_DEPTH];

  logic [BITS_SIZE-1:0] pc_q, pc_d;
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 halted_q, halted_d;

  logic [AW-1:0]        fetch_idx;
  logic [AW-1:0]        load_idx;
  logic                 fetch_in_range;
  logic [BITS_SIZE-1:0] fetch_instr;
  logic                 head_valid;
  logic                 full;
  logic                 advance;
  logic                 push;
  logic                 pop;

  // Low address bits are byte offsets; upper loader bits alias onto the array.
  logic unused_bits;
  assign unused_bits = ^{i_redirect_pc[1:0], i_load_addr};

  assign fetch_idx      = pc_q[AW+1:2];
  assign load_idx       = i_load_addr[AW+1:2];
  assign fetch_in_range = (pc_q >> (AW + 2)) == '0;
  // Combinational read of the pre-write contents: a same-cycle load is not seen.
  assign fetch_instr    = fetch_in_range ? mem_q[fetch_idx] : '0;

  assign head_valid = (count_q != '0);
  assign full       = (count_q == CW'(QUEUE_DEPTH));
  assign advance    = i_step & ~i_redirect;
  assign pop        = advance & head_valid & i_id_ready;
  // A full queue may still accept a push when the head leaves this cycle.
  assign push       = advance & ~halted_q & (~full | pop);

  always_comb begin
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    halted_d = halted_q;
    if (i_step && i_redirect) begin
      pc_d     = {i_redirect_pc[BITS_SIZE-1:2], 2'b00};
      head_d   = '0;
      tail_d   = '0;
      count_d  = '0;
      halted_d = 1'b0;
    end else begin
      if (push) begin
        pc_d   = pc_q + BITS_SIZE'(4);
        tail_d = tail_q + PW'(1);
        // the halt word is itself enqueued; fetching stops after it
        if (fetch_instr == HALT_WORD) halted_d = 1'b1;
      end
      if (pop) head_d = head_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pc_q     <= RESET_PC;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      halted_q <= halted_d;
    end
  end

  // Entry payload needs no reset: outputs are gated by o_valid.
  always_ff @(posedge i_clk) begin
    if (!i_reset && push) begin
      q_pc_q[tail_q]    <= pc_q;
      q_instr_q[tail_q] <= fetch_instr;
    end
  end

  // Loader writes land regardless of i_step and i_reset.
  always_ff @(posedge i_clk) begin
    if (i_load_we) mem_q[load_idx] <= i_load_data;
  end

  // Outputs come straight from registered state: no path from i_id_ready.
  assign o_valid       = head_valid;
  assign o_instruction = head_valid ? q_instr_q[head_q] : '0;
  assign o_pc          = head_valid ? q_pc_q[head_q] : '0;
  assign o_pc4         = head_valid ? q_pc_q[head_q] + BITS_SIZE'(4) : '0;
  assign o_pc8         = head_valid ? q_pc_q[head_q] + BITS_SIZE'(8) : '0;
  assign o_count       = count_q;
  assign o_halt        = halted_q & ~head_valid;

endmodule

// File: tb/tb_if_fetch_queue.sv
module tb_if_fetch_queue;
  localparam int          MEM_WORDS = 64;
  localparam int          DEPTH     = 4;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] HALT      = 32'hFFFFFFFF;

  logic        clk;
  logic        rst, step, we, redir, ready;
  logic [31:0] addr, data, rpc;
  logic        o_valid, o_halt;
  logic [31:0] o_instr, o_pc, o_pc4, o_pc8;
  logic [2:0]  o_count;

  int n_vec = 0;
  int n_err = 0;

  // behavioural reference: memory image, fetch PC, FIFO of {pc, instr}
  logic [31:0] m_mem [MEM_WORDS];
  logic [31:0] m_qpc [$];
  logic [31:0] m_qin [$];
  logic [31:0] m_pc;
  bit          m_halted;

  if_fetch_queue dut (
    .i_clk(clk), .i_reset(rst), .i_step(step),
    .i_load_we(we), .i_load_addr(addr), .i_load_data(data),
    .i_redirect(redir), .i_redirect_pc(rpc), .i_id_ready(ready),
    .o_valid(o_valid), .o_instruction(o_instr), .o_pc(o_pc),
    .o_pc4(o_pc4), .o_pc8(o_pc8), .o_count(o_count), .o_halt(o_halt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_edge();
    logic [31:0] f;
    bit p_pop, p_push;
    f = ((m_pc >> 2) < MEM_WORDS) ? m_mem[m_pc >> 2] : 32'h0;
    if (rst) begin
      m_qpc.delete(); m_qin.delete(); m_pc = RESET_PC; m_halted = 0;
    end else if (step) begin
      if (redir) begin
        m_qpc.delete(); m_qin.delete(); m_pc = rpc & ~32'h3; m_halted = 0;
      end else begin
        p_pop  = (m_qpc.size() > 0) && ready;
        p_push = !m_halted && (m_qpc.size() < DEPTH || p_pop);
        if (p_pop) begin void'(m_qpc.pop_front()); void'(m_qin.pop_front()); end
        if (p_push) begin
          m_qpc.push_back(m_pc); m_qin.push_back(f);
          if (f == HALT) m_halted = 1;
          m_pc = m_pc + 32'd4;
        end
      end
    end
    if (we) m_mem[(addr >> 2) % MEM_WORDS] = data;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    step = 0; we = 1; addr = a; data = d;
    tick();
    we = 0;
  endtask

  task automatic do_reset();
    rst = 1; step = 0; redir = 0; ready = 0; we = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < MEM_WORDS; i++) load(i * 4, 32'hA000 + i);
    load(32'h0, 32'h11); load(32'h4, 32'h22); load(32'h8, 32'h33);
    rst = 1; step = 1; ready = 1;
    tick();
    rst = 0; step = 0;
    n_vec++;
    if ({o_valid, o_count, o_halt} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl got v=%b c=%0d h=%b want 0", o_valid, o_count, o_halt);
    end
    n_vec++;
    if ({o_pc, o_pc4, o_pc8, o_instr} !== 128'h0) begin
      n_err++; $display("FAIL reset_data got pc=%h pc4=%h pc8=%h in=%h want 0", o_pc, o_pc4, o_pc8, o_instr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_in [3];
    exp_in[0] = 32'h11; exp_in[1] = 32'h22; exp_in[2] = 32'h33;
    do_reset();
    step = 1; ready = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({o_valid, o_pc, o_instr} !== {1'b1, 32'(i * 4), exp_in[i]}) begin
        n_err++; $display("FAIL seq_head%0d got v=%b pc=%h in=%h want pc=%h in=%h", i, o_valid, o_pc, o_instr, i * 4, exp_in[i]);
      end
      n_vec++;
      if ({o_pc4, o_pc8} !== {32'(i * 4 + 4), 32'(i * 4 + 8)}) begin
        n_err++; $display("FAIL seq_pc48_%0d got %h %h", i, o_pc4, o_pc8);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    step = 1; ready = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      n_vec++;
      if ({o_count, o_pc} !== {3'((k < 4) ? k : 4), 32'h0}) begin
        n_err++; $display("FAIL bp_fill%0d got cnt=%0d pc=%h", k, o_count, o_pc);
      end
    end
    ready = 1;
    for (int j = 0; j < 8; j++) begin
      tick();
      n_vec++;
      if ({o_count, o_pc, o_instr} !== {3'd4, 32'(4 * (j + 1)), m_mem[j + 1]}) begin
        n_err++; $display("FAIL bp_drain%0d got cnt=%0d pc=%h in=%h want pc=%h in=%h", j, o_count, o_pc, o_instr, 4 * (j + 1), m_mem[j + 1]);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    step = 1; ready = 0;
    repeat (4) tick();
    redir = 1; rpc = 32'h23;
    tick();
    n_vec++;
    if ({o_count, o_valid, o_instr} !== {3'd0, 1'b0, 32'h0}) begin
      n_err++; $display("FAIL redir_flush got cnt=%0d v=%b in=%h", o_count, o_valid, o_instr);
    end
    redir = 0;
    tick();
    n_vec++;
    if ({o_valid, o_count, o_pc, o_instr} !== {1'b1, 3'd1, 32'h20, m_mem[8]}) begin
      n_err++; $display("FAIL redir_target got v=%b cnt=%0d pc=%h in=%h want pc=20", o_valid, o_count, o_pc, o_instr);
    end
    redir = 1; rpc = 32'hFFFFFFFC;
    tick();
    redir = 0;
    tick();
    n_vec++;
    if ({o_pc, o_pc4, o_pc8, o_instr} !== {32'hFFFFFFFC, 32'h0, 32'h4, 32'h0}) begin
      n_err++; $display("FAIL redir_wrap got pc=%h pc4=%h pc8=%h in=%h", o_pc, o_pc4, o_pc8, o_instr);
    end
    tick();
    n_vec++;
    if (o_count !== 3'd2) begin
      n_err++; $display("FAIL redir_wrap_push got cnt=%0d want 2", o_count);
    end
  endtask

  task automatic test_halt();
    load(32'hC, HALT);
    do_reset();
    step = 1; ready = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_vec++;
      if ({o_valid, o_pc, o_halt} !== {1'b1, 32'(i * 4), 1'b0}) begin
        n_err++; $display("FAIL halt_head%0d got v=%b pc=%h h=%b", i, o_valid, o_pc, o_halt);
      end
    end
    tick();
    n_vec++;
    if ({o_valid, o_count, o_halt} !== {1'b0, 3'd0, 1'b1}) begin
      n_err++; $display("FAIL halt_drained got v=%b cnt=%0d h=%b", o_valid, o_count, o_halt);
    end
    tick();
    n_vec++;
    if ({o_count, o_halt} !== {3'd0, 1'b1}) begin
      n_err++; $display("FAIL halt_stall got cnt=%0d h=%b", o_count, o_halt);
    end
    redir = 1; rpc = 32'h0;
    tick();
    n_vec++;
    if ({o_count, o_halt} !== {3'd0, 1'b0}) begin
      n_err++; $display("FAIL halt_clear got cnt=%0d h=%b", o_count, o_halt);
    end
    redir = 0;
    tick();
    n_vec++;
    if ({o_valid, o_pc, o_instr} !== {1'b1, 32'h0, 32'h11}) begin
      n_err++; $display("FAIL halt_resume got v=%b pc=%h in=%h", o_valid, o_pc, o_instr);
    end
    load(32'hC, 32'hA003);
  endtask

  task automatic test_step_freeze();
    do_reset();
    step = 1; ready = 0;
    repeat (2) tick();
    step = 0; ready = 1; redir = 1; rpc = 32'h40;
    we = 1; addr = 32'h8; data = 32'hBEEF;
    tick();
    we = 0; redir = 0;
    n_vec++;
    if ({o_count, o_pc, o_instr} !== {3'd2, 32'h0, 32'h11}) begin
      n_err++; $display("FAIL freeze got cnt=%0d pc=%h in=%h", o_count, o_pc, o_instr);
    end
    step = 1;
    tick();
    tick();
    n_vec++;
    if ({o_pc, o_instr} !== {32'h8, 32'hBEEF}) begin
      n_err++; $display("FAIL freeze_load got pc=%h in=%h want 8/beef", o_pc, o_instr);
    end
    load(32'h8, 32'h33);
  endtask

  task automatic test_reset_mid();
    do_reset();
    step = 1; ready = 0;
    repeat (4) tick();
    rst = 1; redir = 1; rpc = 32'h30; we = 1; addr = 32'h0; data = 32'h77;
    tick();
    n_vec++;
    if ({o_valid, o_count, o_halt, o_pc, o_instr} !== 69'h0) begin
      n_err++; $display("FAIL rstmid got v=%b cnt=%0d h=%b pc=%h in=%h", o_valid, o_count, o_halt, o_pc, o_instr);
    end
    rst = 0; redir = 0; we = 0; ready = 1;
    tick();
    n_vec++;
    if ({o_valid, o_pc, o_instr} !== {1'b1, RESET_PC, 32'h77}) begin
      n_err++; $display("FAIL rstmid_first got v=%b pc=%h in=%h", o_valid, o_pc, o_instr);
    end
    tick();
    n_vec++;
    if ({o_pc, o_instr} !== {32'h4, 32'h22}) begin
      n_err++; $display("FAIL rstmid_mem got pc=%h in=%h", o_pc, o_instr);
    end
    load(32'h0, 32'h11);
  endtask

  task automatic test_random();
    bit          e_valid;
    logic [31:0] e_pc, e_in;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 99) < 2);
      step  = ($urandom_range(0, 3) != 0);
      ready = $urandom_range(0, 1);
      redir = ($urandom_range(0, 9) == 0);
      rpc   = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | $urandom_range(0, 15))
                                           : 32'($urandom_range(0, MEM_WORDS * 4 + 31));
      we    = ($urandom_range(0, 6) == 0);
      addr  = $urandom;
      data  = ($urandom_range(0, 3) == 0) ? HALT : $urandom;
      tick();
      e_valid = (m_qpc.size() != 0);
      e_pc    = e_valid ? m_qpc[0] : 32'h0;
      e_in    = e_valid ? m_qin[0] : 32'h0;
      n_vec++;
      if ({o_valid, o_count, o_halt} !== {e_valid, 3'(m_qpc.size()), (m_halted && !e_valid)}) begin
        n_err++; $display("FAIL rnd_ctrl%0d got v=%b cnt=%0d h=%b want v=%b cnt=%0d h=%b", c, o_valid, o_count, o_halt, e_valid, m_qpc.size(), m_halted && !e_valid);
      end
      n_vec++;
      if ({o_pc, o_pc4, o_pc8, o_instr} !== {e_pc, e_valid ? e_pc + 32'd4 : 32'h0, e_valid ? e_pc + 32'd8 : 32'h0, e_in}) begin
        n_err++; $display("FAIL rnd_data%0d got pc=%h in=%h want pc=%h in=%h", c, o_pc, o_instr, e_pc, e_in);
      end
    end
    rst = 0; we = 0; redir = 0; step = 0;
  endtask

  initial begin
    rst = 0; step = 0; we = 0; redir = 0; ready = 0;
    addr = 0; data = 0; rpc = 0;
    m_pc = RESET_PC; m_halted = 0;
    for (int i = 0; i < MEM_WORDS; i++) m_mem[i] = 32'h0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_halt();
    test_step_freeze();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

Interface
REQ-001 SHALL have parameter BITS_SIZE, default 32, datapath/address width.
REQ-002 SHALL have parameter MEM_WORDS, default 64, instruction memory depth in words (power of 2).
REQ-003 SHALL have parameter QUEUE_DEPTH, default 4, fetch queue entries (power of 2, >=2).
REQ-004 SHALL have parameter RESET_PC, default 0, PC after reset.
REQ-005 SHALL have parameter HALT_WORD, default 32'hFFFFFFFF, halt instruction encoding.
REQ-006 SHALL have i_clk  in  1  single clock; all state updates on rising edge.
REQ-007 SHALL have i_reset  in  1  reset, synchronous, active-high.
REQ-008 SHALL have i_step  in  1  global advance enable; 0 freezes PC, queue, halt state.
REQ-009 SHALL have i_load_we  in  1  loader write strobe into instruction memory.
REQ-010 SHALL have i_load_addr  in  BITS_SIZE  loader byte address (word index = addr[log2(MEM_WORDS)+1:2]).
REQ-011 SHALL have i_load_data  in  BITS_SIZE  loader write data.
REQ-012 SHALL have i_redirect  in  1  taken branch/jump/JALR redirect strobe.
REQ-013 SHALL have i_redirect_pc  in  BITS_SIZE  redirect target.
REQ-014 SHALL have i_id_ready  in  1  decode stage accepts head entry.
REQ-015 SHALL have o_valid  out  1  head entry valid.
REQ-016 SHALL have o_instruction, o_pc, o_pc4, o_pc8  out  BITS_SIZE each  head instruction, its PC, PC+4, PC+8.
REQ-017 SHALL have o_count  out  log2(QUEUE_DEPTH)+1  occupied entries.
REQ-018 SHALL have o_halt  out  1  halted and queue drained.

Function
REQ-019 SHALL read memory combinationally at word index of fetch PC; PC outside MEM_WORDS range SHALL read 0.
REQ-020 SHALL write memory on i_load_we at any time, independent of i_step; same-cycle fetch of that word SHALL see old data.
REQ-021 SHALL push {PC, instruction} and set PC<=PC+4 when i_step=1, not halted, no redirect, and (count<QUEUE_DEPTH or pop this cycle).
REQ-022 SHALL pop head when i_step=1, o_valid=1, i_id_ready=1 and no redirect.
REQ-023 SHALL allow simultaneous push and pop, including when full (count unchanged) and when empty-with-pop impossible (push only).
REQ-024 SHALL, on i_redirect=1 with i_step=1, flush queue (count=0), set PC<=i_redirect_pc with bits[1:0] forced 0, clear halt, push nothing, pop nothing that cycle.
REQ-025 SHALL ignore i_redirect when i_step=0.
REQ-026 SHALL set halted when a pushed instruction equals HALT_WORD; the halt word SHALL itself be enqueued; no further pushes until redirect or reset.
REQ-027 SHALL drive o_halt=1 when halted and count=0.
REQ-028 SHALL wrap PC, PC+4, PC+8 modulo 2^BITS_SIZE.
REQ-029 SHALL present head entry with zero combinational path from i_id_ready to outputs; o_instruction/o_pc SHALL hold while o_valid=1 and not popped.
REQ-030 SHALL give first-instruction latency of one edge: push at first enabled edge after reset, o_valid=1 thereafter.
REQ-031 SHALL drive o_instruction, o_pc, o_pc4, o_pc8 to 0 when o_valid=0.

Reset
REQ-032 SHALL on i_reset=1 (regardless of i_step) set PC=RESET_PC, count=0, halted=0, o_valid=0, o_halt=0, all data outputs 0.
REQ-033 SHALL retain memory contents through reset; loader write in reset cycle SHALL still occur.
REQ-034 SHALL give reset priority over redirect, push and pop.

Verification
REQ-035 Load words 0x11,0x22,0x33 at 0,4,8; reset; i_step=1, i_id_ready=1 -> o_pc 0,4,8 with instructions 0x11,0x22,0x33 on consecutive cycles, o_pc4/o_pc8 = o_pc+4/+8.
REQ-036 i_id_ready=0 for 6 cycles, QUEUE_DEPTH=4 -> o_count saturates at 4, PC stops at 0x10, head stays PC 0; release -> order preserved, no loss/duplication.
REQ-037 Queue full, assert i_redirect with i_redirect_pc=0x23 -> next cycle count=0, o_valid=0; following edge head PC=0x20.
REQ-038 HALT_WORD at address 0xC -> entries 0,4,8,0xC enqueued, PC stalls at 0x10; o_halt=1 after 0xC popped; redirect to 0 clears halt, fetch resumes.
REQ-039 i_step=0 mid-stream with i_id_ready=1 and i_redirect=1 -> no state change; load write still lands.
REQ-040 i_reset pulsed with full queue and redirect asserted -> count=0, PC=RESET_PC, memory intact, first instruction reappears after one edge.
